// File: rtl/costas_lock_ctrl.sv
// Lock supervisor and gain scheduler for the polar Costas loop: windowed mean(|I|-|Q|)
// lock metric, IDLE/ACQ/TRACK sequencing, gain selection and loop-filter/NCO clears.
module costas_lock_ctrl #(
  parameter int unsigned WIN_LOG2      = 8,
  parameter int          LOCK_THRESH   = 16000,
  parameter int          UNLOCK_THRESH = 8000,
  parameter int unsigned LOCK_CNT      = 4,
  parameter int unsigned UNLOCK_CNT    = 2,
  parameter int unsigned ACQ_TIMEOUT   = 64,
  parameter int unsigned KP_ACQ        = 4,
  parameter int unsigned KI_ACQ        = 10,
  parameter int unsigned KP_TRK        = 7,
  parameter int unsigned KI_TRK        = 14
) (
  input  logic        ce_clk,
  input  logic        ce_rst,
  input  logic        enable,
  input  logic        in_valid,
  input  logic [15:0] i_sync,
  input  logic [15:0] q_sync,
  output logic [4:0]  kp_shift,
  output logic [4:0]  ki_shift,
  output logic        gain_upd,
  output logic        loop_clear,
  output logic        locked,
  output logic [16:0] lock_metric,
  output logic        metric_valid,
  output logic [7:0]  retry_cnt
);

  localparam int unsigned AccW = 17 + WIN_LOG2;
  localparam logic signed [16:0] LockThr   = 17'(LOCK_THRESH);
  localparam logic signed [16:0] UnlockThr = 17'(UNLOCK_THRESH);
  localparam logic [3:0] LockCnt   = 4'(LOCK_CNT);
  localparam logic [3:0] UnlockCnt = 4'(UNLOCK_CNT);
  localparam logic [7:0] AcqTmo    = 8'(ACQ_TIMEOUT);
  localparam logic [4:0] KpAcq = 5'(KP_ACQ);
  localparam logic [4:0] KiAcq = 5'(KI_ACQ);
  localparam logic [4:0] KpTrk = 5'(KP_TRK);
  localparam logic [4:0] KiTrk = 5'(KI_TRK);

  typedef enum logic [1:0] {StIdle, StAcq, StTrack} state_e;

  state_e                state_q, state_d;
  logic signed [AccW-1:0] acc_q, acc_d;
  logic [WIN_LOG2-1:0]   cnt_q, cnt_d;
  logic [3:0]            good_q, good_d, bad_q, bad_d;
  logic [7:0]            acq_win_q, acq_win_d, retry_q, retry_d;
  logic [4:0]            kp_q, kp_d, ki_q, ki_d;
  logic                  gain_upd_q, gain_upd_d, clear_q, clear_d, locked_q, locked_d;
  logic signed [16:0]    metric_q, metric_d;
  logic                  mvalid_q, mvalid_d;

  logic [15:0]            abs_i, abs_q;
  logic signed [16:0]     term;
  logic signed [AccW-1:0] term_ext, sum;
  logic                   accept, restart;
  logic [3:0]             good_nxt, bad_nxt;
  logic [7:0]             win_nxt, retry_inc;

  // |-32768| would not fit in 16 bits, so it saturates to 32767.
  function automatic logic [15:0] sat_abs(input logic [15:0] x);
    if (x == 16'h8000) return 16'h7fff;
    return x[15] ? (~x + 16'd1) : x;
  endfunction

  assign abs_i     = sat_abs(i_sync);
  assign abs_q     = sat_abs(q_sync);
  assign term      = $signed({1'b0, abs_i}) - $signed({1'b0, abs_q});
  assign term_ext  = {{WIN_LOG2{term[16]}}, term};
  assign sum       = acc_q + term_ext;
  assign accept    = in_valid && !clear_q && (state_q != StIdle);
  assign retry_inc = (retry_q == 8'hff) ? retry_q : retry_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    good_d    = good_q;
    bad_d     = bad_q;
    acq_win_d = acq_win_q;
    retry_d   = retry_q;
    metric_d  = metric_q;
    mvalid_d  = 1'b0;
    clear_d   = 1'b0;
    restart   = 1'b0;
    good_nxt  = (metric_q >= LockThr) ? good_q + 4'd1 : 4'd0;
    bad_nxt   = (metric_q < UnlockThr) ? bad_q + 4'd1 : 4'd0;
    win_nxt   = acq_win_q + 8'd1;

    if (accept) begin
      if (&cnt_q) begin
        // Upper bits of the full sum are the arithmetic-shifted mean.
        metric_d = sum[AccW-1:WIN_LOG2];
        mvalid_d = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + WIN_LOG2'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StAcq;
          clear_d = 1'b1;
          restart = 1'b1;
        end
      end
      StAcq: begin
        if (mvalid_q) begin
          good_d    = good_nxt;
          acq_win_d = win_nxt;
          if (good_nxt == LockCnt) begin
            state_d = StTrack;
            restart = 1'b1;
          end else if (win_nxt == AcqTmo) begin
            clear_d = 1'b1;
            restart = 1'b1;
            retry_d = retry_inc;
          end
        end
      end
      StTrack: begin
        if (mvalid_q) begin
          bad_d = bad_nxt;
          if (bad_nxt == UnlockCnt) begin
            state_d = StAcq;
            clear_d = 1'b1;
            restart = 1'b1;
            retry_d = retry_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Disable overrides every decision and drops any window in flight.
    if (!enable) begin
      state_d  = StIdle;
      clear_d  = 1'b0;
      restart  = 1'b1;
      mvalid_d = 1'b0;
      metric_d = metric_q;
      retry_d  = retry_q;
    end

    if (restart) begin
      acc_d     = '0;
      cnt_d     = '0;
      good_d    = '0;
      bad_d     = '0;
      acq_win_d = '0;
    end

    kp_d       = (state_d == StTrack) ? KpTrk : KpAcq;
    ki_d       = (state_d == StTrack) ? KiTrk : KiAcq;
    gain_upd_d = (kp_d != kp_q) || (ki_d != ki_q);
    locked_d   = (state_d == StTrack);
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      cnt_q      <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      acq_win_q  <= '0;
      retry_q    <= '0;
      kp_q       <= KpAcq;
      ki_q       <= KiAcq;
      gain_upd_q <= 1'b0;
      clear_q    <= 1'b0;
      locked_q   <= 1'b0;
      metric_q   <= '0;
      mvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      acq_win_q  <= acq_win_d;
      retry_q    <= retry_d;
      kp_q       <= kp_d;
      ki_q       <= ki_d;
      gain_upd_q <= gain_upd_d;
      clear_q    <= clear_d;
      locked_q   <= locked_d;
      metric_q   <= metric_d;
      mvalid_q   <= mvalid_d;
    end
  end

  assign kp_shift     = kp_q;
  assign ki_shift     = ki_q;
  assign gain_upd     = gain_upd_q;
  assign loop_clear   = clear_q;
  assign locked       = locked_q;
  assign lock_metric  = metric_q;
  assign metric_valid = mvalid_q;
  assign retry_cnt    = retry_q;

endmodule

// File: tb/tb_costas_lock_ctrl.sv
// Scoreboard bench for costas_lock_ctrl: a behavioural model predicts every pulse event
// (metric, clear, gain change) and a negedge monitor compares them with the DUT.
module tb_costas_lock_ctrl;
  localparam int WL = 4, WIN = 16, LOCKT = 16000, UNLOCKT = 8000;
  localparam int LCNT = 4, UCNT = 2, TMO = 4;
  localparam int KPA = 4, KIA = 10, KPT = 7, KIT = 14;

  logic        ce_clk = 1'b0, ce_rst = 1'b1, enable = 1'b0, in_valid = 1'b0;
  logic [15:0] i_sync = '0, q_sync = '0;
  logic [4:0]  kp_shift, ki_shift;
  logic        gain_upd, loop_clear, locked, metric_valid;
  logic [16:0] lock_metric;
  logic [7:0]  retry_cnt;

  always #5 ce_clk = ~ce_clk;

  costas_lock_ctrl #(
    .WIN_LOG2(WL), .LOCK_THRESH(LOCKT), .UNLOCK_THRESH(UNLOCKT), .LOCK_CNT(LCNT),
    .UNLOCK_CNT(UCNT), .ACQ_TIMEOUT(TMO), .KP_ACQ(KPA), .KI_ACQ(KIA), .KP_TRK(KPT),
    .KI_TRK(KIT)
  ) dut (
    .ce_clk(ce_clk), .ce_rst(ce_rst), .enable(enable), .in_valid(in_valid),
    .i_sync(i_sync), .q_sync(q_sync), .kp_shift(kp_shift), .ki_shift(ki_shift),
    .gain_upd(gain_upd), .loop_clear(loop_clear), .locked(locked),
    .lock_metric(lock_metric), .metric_valid(metric_valid), .retry_cnt(retry_cnt)
  );

  typedef struct {
    int cyc; bit mv; int metric; bit lc; bit gu; int kp; int ki; bit lk; int retry;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  n_checks = 0, n_fail = 0, cyc = 0;
  bit  mon_en = 1'b0;

  // Model: state 0 = idle, 1 = acquiring, 2 = tracking. Values are those after the edge.
  int m_state, m_sum, m_n, m_metric, m_good, m_bad, m_acqw, m_retry, m_kp, m_ki;
  bit m_mv, m_lc, m_lk;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int sat_abs(int x);
    int a = (x < 0) ? -x : x;
    return (a > 32767) ? 32767 : a;
  endfunction

  function automatic int floor_div(int a, int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic void model_step(bit rst, bit en, bit v, int i, int q);
    int nstate, nmetric, nkp, nki;
    bit nmv, nlc, restart, gu;
    ev_t e;
    if (rst) begin
      m_state = 0; m_sum = 0; m_n = 0; m_metric = 0; m_mv = 0; m_lc = 0; m_good = 0;
      m_bad = 0; m_acqw = 0; m_retry = 0; m_kp = KPA; m_ki = KIA; m_lk = 0;
      return;
    end
    nstate = m_state; nmetric = m_metric; nmv = 0; nlc = 0; restart = 0;
    if (m_state != 0 && v && !m_lc) begin
      m_sum += sat_abs(i) - sat_abs(q);
      m_n++;
      if (m_n == WIN) begin
        nmv = 1; nmetric = floor_div(m_sum, WIN); m_sum = 0; m_n = 0;
      end
    end
    if (!en) begin
      nstate = 0; restart = 1; nmv = 0; nmetric = m_metric;
    end else if (m_state == 0) begin
      nstate = 1; nlc = 1; restart = 1;
    end else if (m_mv && m_state == 1) begin
      m_good = (m_metric >= LOCKT) ? m_good + 1 : 0;
      m_acqw++;
      if (m_good == LCNT) begin
        nstate = 2; restart = 1;
      end else if (m_acqw == TMO) begin
        nlc = 1; restart = 1; m_retry = (m_retry < 255) ? m_retry + 1 : 255;
      end
    end else if (m_mv && m_state == 2) begin
      m_bad = (m_metric < UNLOCKT) ? m_bad + 1 : 0;
      if (m_bad == UCNT) begin
        nstate = 1; nlc = 1; restart = 1; m_retry = (m_retry < 255) ? m_retry + 1 : 255;
      end
    end
    if (restart) begin
      m_sum = 0; m_n = 0; m_good = 0; m_bad = 0; m_acqw = 0;
    end
    nkp = (nstate == 2) ? KPT : KPA;
    nki = (nstate == 2) ? KIT : KIA;
    gu  = (nkp != m_kp) || (nki != m_ki);
    m_state = nstate; m_metric = nmetric; m_mv = nmv; m_lc = nlc;
    m_kp = nkp; m_ki = nki; m_lk = (nstate == 2);
    if (nmv || nlc || gu) begin
      e.cyc = cyc; e.mv = nmv; e.metric = nmetric; e.lc = nlc; e.gu = gu;
      e.kp = nkp; e.ki = nki; e.lk = m_lk; e.retry = m_retry;
      sb.push_back(e);
    end
  endfunction

  task automatic tick(bit rst, bit en, bit v, int i, int q);
    ce_rst = rst; enable = en; in_valid = v; i_sync = 16'(i); q_sync = 16'(q);
    @(posedge ce_clk);
    cyc++;
    model_step(rst, en, v, i, q);
    #1;
  endtask

  task automatic feed(int n, int i, int q);
    repeat (n) tick(1'b0, 1'b1, 1'b1, i, q);
  endtask

  always @(negedge ce_clk) begin
    if (mon_en) begin
      if (metric_valid || loop_clear || gain_upd) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_event: mv=%0b lc=%0b gu=%0b with no expected event (cycle %0d)",
                   metric_valid, loop_clear, gain_upd, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("event_cycle", cyc, mon_e.cyc);
          check("metric_valid", int'(metric_valid), int'(mon_e.mv));
          if (mon_e.mv) check("lock_metric", int'($signed(lock_metric)), mon_e.metric);
          check("loop_clear", int'(loop_clear), int'(mon_e.lc));
          check("gain_upd", int'(gain_upd), int'(mon_e.gu));
          check("kp_shift", int'(kp_shift), mon_e.kp);
          check("ki_shift", int'(ki_shift), mon_e.ki);
          check("locked", int'(locked), int'(mon_e.lk));
          check("retry_cnt", int'(retry_cnt), mon_e.retry);
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        check("missing_event", int'(metric_valid | loop_clear | gain_upd), 1);
        mon_e = sb.pop_front();
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick(1'b1, 1'b0, 1'b0, 0, 0);
    mon_en = 1'b1;
    check("rst_kp", int'(kp_shift), KPA);
    check("rst_ki", int'(ki_shift), KIA);
    check("rst_locked", int'(locked), 0);
    check("rst_retry", int'(retry_cnt), 0);
    check("rst_metric", int'(lock_metric), 0);
    check("rst_pulses", int'({metric_valid, loop_clear, gain_upd}), 0);

    // Enable: entry clear, then four good windows; lock and timeout coincide, lock wins.
    tick(1'b0, 1'b1, 1'b1, 20000, 1000);
    check("entry_loop_clear", int'(loop_clear), 1);
    feed(79, 20000, 1000);
    check("trk_locked", int'(locked), 1);
    check("trk_kp", int'(kp_shift), KPT);
    check("trk_ki", int'(ki_shift), KIT);
    check("tie_retry", int'(retry_cnt), 0);

    feed(40, -32768, 0);
    check("sat_metric", int'($signed(lock_metric)), 32767);

    // Single bad window followed by a good one keeps lock; two bad windows drop it.
    for (int k = 0; k < 40 && m_n != 0; k++) tick(1'b0, 1'b1, 1'b1, 20000, 1000);
    feed(16, 5000, 5000);
    feed(17, 20000, 1000);
    check("single_bad_locked", int'(locked), 1);
    feed(40, 5000, 5000);
    check("unlock_locked", int'(locked), 0);
    check("unlock_kp", int'(kp_shift), KPA);
    check("unlock_ki", int'(ki_shift), KIA);
    check("unlock_retry", int'(retry_cnt), 1);

    // Repeated acquisition timeouts saturate the retry counter.
    feed(20000, 5000, 5000);
    check("retry_sat", int'(retry_cnt), 255);

    // Disable mid-window in TRACK, then re-enable with a fresh window.
    feed(200, 20000, 1000);
    check("relock", int'(locked), 1);
    for (int k = 0; k < 40 && m_n != 0; k++) tick(1'b0, 1'b1, 1'b1, 20000, 1000);
    feed(5, -32768, 0);
    tick(1'b0, 1'b0, 1'b1, 20000, 1000);
    check("dis_locked", int'(locked), 0);
    check("dis_no_clear", int'(loop_clear), 0);
    check("dis_kp", int'(kp_shift), KPA);
    tick(1'b0, 1'b0, 1'b1, 20000, 1000);
    tick(1'b0, 1'b0, 1'b1, 20000, 1000);
    feed(18, 20000, 1000);
    check("fresh_mvalid", int'(metric_valid), 1);
    check("fresh_metric", int'($signed(lock_metric)), 19000);

    // Randomized windows of good, bad, marginal and arbitrary samples.
    for (int w = 0; w < 150; w++) begin
      int mode;
      mode = $urandom_range(0, 3);
      for (int k = 0; k < 20; k++) begin
        int i, q;
        bit v, en, rst;
        v   = ($urandom_range(0, 3) != 0);
        en  = ($urandom_range(0, 299) != 0);
        rst = (w == 75 && k == 7);
        case (mode)
          0: begin i = $urandom_range(17000, 32767); q = $urandom_range(0, 800); end
          1: begin i = $urandom_range(0, 30000); q = i + $urandom_range(0, 500); end
          2: begin i = $urandom_range(8000, 24000); q = $urandom_range(0, 8000); end
          default: begin i = $urandom_range(0, 65535) - 32768;
                         q = $urandom_range(0, 65535) - 32768; end
        endcase
        if ($urandom_range(0, 1) != 0) i = -i;
        if ($urandom_range(0, 1) != 0) q = -q;
        if (i < -32768) i = -32768;
        tick(rst, en, v, i, q);
      end
    end

    repeat (4) tick(1'b0, 1'b1, 1'b0, 0, 0);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
